// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - word-wide memory request/response channel used by mem_bridge
//
// Signals:
//   m_valid  : request valid (bridge -> memory)
//   m_ready  : memory accepts the request (memory -> bridge)
//   m_we     : write request (bridge -> memory)
//   m_addr   : word-aligned byte address (bridge -> memory)
//   m_be     : byte enables (bridge -> memory)
//   m_wdata  : lane-replicated store data (bridge -> memory)
//   m_rvalid : read data valid (memory -> bridge)
//   m_rdata  : raw read word (memory -> bridge)
// Modports: master = bridge side, slave = memory side.
interface mem_bridge_if;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_be, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_be, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - single-access bridge from the multicycle core to word-wide memory
//
// Turns one controller request into one memory transaction with byte enables,
// lane-aligns store data and sign/zero-extends load data.
//
// Ports:
//   clk, reset (async, active low)
//   req, we, fetch, func3[2:0], addr[31:0], wdata[31:0] : access request from the controller
//   rdata[31:0] : formatted load data, held until the next load capture
//   busy        : access in flight (REQ or RESP)
//   done, err   : one-cycle completion pulse, err on timeout or misalignment trap
//   mem         : mem_bridge_if.master memory request/response channel
// Parameter WAIT_MAX: cycles allowed in REQ or RESP before aborting with err.
// Build option MISALIGN_TRAP_EN: when defined, misaligned half/word accesses complete
// immediately with err and no memory transaction; otherwise the offset is forced aligned.
module mem_bridge #(
    parameter int WAIT_MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic         fetch,
    input  logic [2:0]   func3,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         busy,
    output logic         done,
    output logic         err,
    mem_bridge_if.master mem
);
    // The counter only needs to reach WAIT_MAX-1; the state change happens on that cycle.
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic         we_q;
    logic         sign_q;
    size_t        size_q;
    logic [1:0]   off_q;
    logic         err_q;

    size_t        size_in;
    logic [1:0]   off_in;
    logic [3:0]   be_in;
    logic [31:0]  wdata_in;
    logic         misalign_in;

    logic         capture;
    logic         err_set;
    logic [31:0]  shifted;
    logic [31:0]  load_fmt;

    // Decode the request as presented in IDLE; results are latched on acceptance.
    always_comb begin
        size_in  = SZ_WORD;
        off_in   = 2'b00;
        be_in    = 4'b1111;
        wdata_in = wdata;
        if (!fetch && !func3[1]) begin
            size_in = func3[0] ? SZ_HALF : SZ_BYTE;
        end
        case (size_in)
            SZ_BYTE: begin
                off_in   = addr[1:0];
                be_in    = 4'b0001 << addr[1:0];
                wdata_in = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                // Low address bit dropped so a half never straddles the word.
                off_in   = {addr[1], 1'b0};
                be_in    = 4'b0011 << {addr[1], 1'b0};
                wdata_in = {2{wdata[15:0]}};
            end
            default: begin
                off_in   = 2'b00;
                be_in    = 4'b1111;
                wdata_in = wdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_in = ((size_in == SZ_HALF) && addr[0]) ||
                         ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign misalign_in = 1'b0;
`endif

    assign shifted = mem.m_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (size_q)
            SZ_BYTE: load_fmt = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_fmt = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = misalign_in ? S_DONE : S_REQ;
                    err_set = misalign_in;
                end
            end
            S_REQ: begin
                // Progress on the last allowed cycle wins over the timeout.
                if (mem.m_ready) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (mem.m_rvalid) begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end
            end
            S_RESP: begin
                if (mem.m_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // m_valid is decoded from state so an asynchronous reset drops it immediately.
    assign mem.m_valid = (state_q == S_REQ);
    assign busy        = (state_q == S_REQ) || (state_q == S_RESP);
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_DONE) && err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            rdata       <= '0;
            mem.m_we    <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_be    <= '0;
            mem.m_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if ((state_q == S_IDLE) && req) begin
                we_q        <= we;
                sign_q      <= ~func3[2];
                size_q      <= size_in;
                off_q       <= off_in;
                mem.m_we    <= we;
                mem.m_addr  <= {addr[31:2], 2'b00};
                mem.m_be    <= be_in;
                mem.m_wdata <= wdata_in;
            end
            if (capture) begin
                rdata <= load_fmt;
            end
            if (state_d == S_DONE) begin
                err_q <= err_set;
            end
        end
    end
endmodule
